// File: rtl/alu_bist.sv
// Exhaustive self-test sequencer and MISR compactor for a combinational ALU.
// Optional abort input is enabled by defining ALU_BIST_ABORT_EN.
module alu_bist #(
    parameter int unsigned       W     = 4,
    parameter int unsigned       OC_W  = 3,
    parameter int unsigned       SIG_W = 16,
    parameter logic [SIG_W-1:0]  POLY  = 16'h1021,
    parameter logic [SIG_W-1:0]  SEED  = 16'hFFFF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [SIG_W-1:0] golden,
`ifdef ALU_BIST_ABORT_EN
    input  logic             abort,
`endif
    output logic [OC_W-1:0]  alu_oc,
    output logic [W-1:0]     alu_a,
    output logic [W-1:0]     alu_b,
    input  logic [W-1:0]     alu_f,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [SIG_W-1:0] signature
);

    localparam int unsigned IDX_W = OC_W + 2 * W;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [SIG_W-1:0]   misr_q, misr_d;
    logic               done_q, done_d;
    logic               pass_q, pass_d;

    logic [SIG_W-1:0]   misr_step;
    logic               last_vec;
    logic               abort_req;

`ifdef ALU_BIST_ABORT_EN
    always_comb abort_req = abort;
`else
    always_comb abort_req = 1'b0;
`endif

    always_comb begin
        misr_step = {misr_q[SIG_W-2:0], 1'b0}
                  ^ (misr_q[SIG_W-1] ? POLY : '0)
                  ^ {{(SIG_W-W){1'b0}}, alu_f};
        last_vec  = (idx_q == '1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            misr_q  <= SEED;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            misr_q  <= misr_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        misr_d  = misr_q;
        done_d  = done_q;
        pass_d  = pass_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_RUN;
                    idx_d   = '0;
                    misr_d  = SEED;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                end
            end
            S_RUN: begin
                // Abort leaves the partial signature visible and wins over completion.
                if (abort_req) begin
                    state_d = S_IDLE;
                    idx_d   = '0;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                end else begin
                    misr_d = misr_step;
                    idx_d  = idx_q + 1'b1;
                    if (last_vec) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        pass_d  = (misr_step == golden);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                idx_d   = '0;
                misr_d  = SEED;
                done_d  = 1'b0;
                pass_d  = 1'b0;
            end
        endcase
    end

    always_comb begin
        busy                    = (state_q == S_RUN);
        done                    = done_q;
        pass                    = pass_q;
        signature               = misr_q;
        {alu_oc, alu_a, alu_b}  = busy ? idx_q : '0;
    end

endmodule
